// File: rtl/fetch_ctrl.sv
// fetch_ctrl: front-end redirect/stall/flush arbiter with boot wait and debug halt; optional perf counters via FETCH_CTRL_PERF_EN
module fetch_ctrl #(
  parameter int BOOT_CYCLES = 4,
  parameter int ADDR_W      = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              trap_vld,
  input  logic [ADDR_W-1:0] trap_vec,
  input  logic              mret_vld,
  input  logic [ADDR_W-1:0] mepc,
  input  logic              ex_br_vld,
  input  logic [ADDR_W-1:0] ex_br_addr,
  input  logic              id_jal_vld,
  input  logic [ADDR_W-1:0] id_jal_addr,
  input  logic              load_use,
  input  logic              mdu_busy,
  input  logic              halt_req,
  input  logic              resume,
  output logic              jmp_vld,
  output logic [ADDR_W-1:0] jmp_addr,
  output logic              hold,
  output logic              flush_if_id,
  output logic              flush_id_ex,
  output logic              stall_id,
  output logic [1:0]        state
`ifdef FETCH_CTRL_PERF_EN
  ,
  output logic [31:0]       perf_stall_cnt,
  output logic [31:0]       perf_redirect_cnt,
  output logic [31:0]       perf_flush_cnt
`endif
);
  typedef enum logic [1:0] {BOOT = 2'b00, RUN = 2'b01, HALT = 2'b10} state_t;
  localparam logic [7:0] BOOT_INIT = 8'(BOOT_CYCLES - 1);
  state_t state_q, state_d;
  logic [7:0] cnt_q, cnt_d;
  logic jal_ok, redir, hard;
  logic [ADDR_W-1:0] tgt;
  // a jal in ID cannot leave while the MDU holds EX, so it waits
  assign jal_ok = id_jal_vld & ~mdu_busy;
  assign hard   = trap_vld | mret_vld | ex_br_vld;
  assign redir  = hard | jal_ok;
  assign tgt    = trap_vld ? trap_vec : mret_vld ? mepc : ex_br_vld ? ex_br_addr : id_jal_addr;
  assign state  = state_q;
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    jmp_vld     = 1'b0;
    jmp_addr    = '0;
    hold        = 1'b1;
    flush_if_id = 1'b1;
    flush_id_ex = 1'b1;
    stall_id    = 1'b0;
    case (state_q)
      BOOT: begin
        cnt_d   = cnt_q == 8'd0 ? cnt_q : cnt_q - 8'd1;
        state_d = cnt_q == 8'd0 ? RUN : BOOT;
      end
      RUN: begin
        jmp_vld     = redir;
        jmp_addr    = redir ? tgt & ~ADDR_W'(3) : '0;
        hold        = ~redir & (load_use | mdu_busy);
        stall_id    = ~redir & (load_use | mdu_busy);
        flush_if_id = redir;
        flush_id_ex = hard | (~redir & load_use);
        state_d     = halt_req & ~redir ? HALT : RUN;
      end
      HALT: begin
        stall_id    = 1'b1;
        flush_if_id = 1'b0;
        state_d     = resume & ~halt_req ? RUN : HALT;
      end
      default: begin
        state_d = BOOT;
        cnt_d   = BOOT_INIT;
      end
    endcase
    if (rst) begin
      jmp_vld     = 1'b0;
      jmp_addr    = '0;
      hold        = 1'b1;
      flush_if_id = 1'b1;
      flush_id_ex = 1'b1;
      stall_id    = 1'b0;
    end
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= BOOT;
      cnt_q   <= BOOT_INIT;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end
`ifdef FETCH_CTRL_PERF_EN
  logic [31:0] stall_q, stall_d, rdr_q, rdr_d, fl_q, fl_d;
  logic run;
  assign run = state_q == RUN;
  always_comb begin
    stall_d = (run & hold & ~&stall_q) ? stall_q + 32'd1 : stall_q;
    rdr_d   = (jmp_vld & ~&rdr_q) ? rdr_q + 32'd1 : rdr_q;
    fl_d    = (run & flush_id_ex & ~&fl_q) ? fl_q + 32'd1 : fl_q;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      stall_q <= '0;
      rdr_q   <= '0;
      fl_q    <= '0;
    end else begin
      stall_q <= stall_d;
      rdr_q   <= rdr_d;
      fl_q    <= fl_d;
    end
  end
  assign perf_stall_cnt    = stall_q;
  assign perf_redirect_cnt = rdr_q;
  assign perf_flush_cnt    = fl_q;
`endif
endmodule
